or16_rr_sched: RTL and testbench

OR16_RR_SCHED -- requirements
Module: or16_rr_sched

---
 rtl/or16_rr_sched_if.sv | 36 +++
 rtl/or16_rr_sched.sv | 119 +++++++++++
 tb/tb_or16_rr_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/or16_rr_sched_if.sv
// rtl/or16_rr_sched_if.sv - request/result bundle for the round-robin OR scheduler
//
// Signals:
//   req       3        per-requester pending flag
//   in_a/in_b 3*WIDTH  operands, requester i on [i*WIDTH +: WIDTH]
//   gnt       3        one-hot grant, operands captured this cycle
//   res       WIDTH    registered OR result
//   res_id    2        requester that owns res
//   res_valid 1        res/res_id valid
//   res_ready 1        consumer accepts res this cycle
//   busy      1        scheduler holds a result
//   done_cnt  8        completed result handshakes (wraps)
interface or16_rr_sched_if #(
    parameter int WIDTH = 16
);
    logic [2:0]         req;
    logic [3*WIDTH-1:0] in_a;
    logic [3*WIDTH-1:0] in_b;
    logic [2:0]         gnt;
    logic [WIDTH-1:0]   res;
    logic [1:0]         res_id;
    logic               res_valid;
    logic               res_ready;
    logic               busy;
    logic [7:0]         done_cnt;

    modport slave (
        input  req, in_a, in_b, res_ready,
        output gnt, res, res_id, res_valid, busy, done_cnt
    );

    modport master (
        output req, in_a, in_b, res_ready,
        input  gnt, res, res_id, res_valid, busy, done_cnt
    );
endinterface

// File: rtl/or16_rr_sched.sv
// rtl/or16_rr_sched.sv - three-requester round-robin scheduler for a shared bitwise-OR unit
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  or16_rr_sched_if.slave: req/in_a/in_b/res_ready in,
//        gnt/res/res_id/res_valid/busy/done_cnt out
module or16_rr_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    or16_rr_sched_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         last;
    logic [1:0]         pick1;
    logic [1:0]         pick2;
    logic [1:0]         win_idx;
    logic               win_valid;
    logic               fire;
    logic               handshake;
    logic [2:0]         gnt_c;
    logic [WIDTH-1:0]   op_or;
    logic [WIDTH-1:0]   res_q;
    logic [1:0]         res_id_q;
    logic [7:0]         done_cnt_q;

    // Search order after the last winner: last+1, last+2, last (mod 3).
    always_comb begin
        pick1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        pick2 = (pick1 == 2'd2) ? 2'd0 : pick1 + 2'd1;
    end

    always_comb begin
        win_valid = 1'b1;
        win_idx   = 2'd0;
        if (bus.req[pick1]) begin
            win_idx = pick1;
        end else if (bus.req[pick2]) begin
            win_idx = pick2;
        end else if (bus.req[last]) begin
            win_idx = last;
        end else begin
            win_valid = 1'b0;
        end
    end

    // Only the winner's lane reaches the OR unit, so other operands cannot leak into res.
    always_comb begin
        case (win_idx)
            2'd0:    op_or = bus.in_a[0*WIDTH +: WIDTH] | bus.in_b[0*WIDTH +: WIDTH];
            2'd1:    op_or = bus.in_a[1*WIDTH +: WIDTH] | bus.in_b[1*WIDTH +: WIDTH];
            default: op_or = bus.in_a[2*WIDTH +: WIDTH] | bus.in_b[2*WIDTH +: WIDTH];
        endcase
    end

    assign handshake = (state == HOLD) && bus.res_ready;

    // A new grant is possible when nothing is held, or when the held result
    // leaves this cycle; that gives one operation per cycle when streaming.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        gnt_c     = 3'b000;
        if (!rst && win_valid && ((state == IDLE) || bus.res_ready)) begin
            fire  = 1'b1;
            gnt_c = 3'b001 << win_idx;
        end
        case (state)
            IDLE: begin
                if (fire) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_nxt = fire ? HOLD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 2'd2;
            res_q      <= '0;
            res_id_q   <= 2'd0;
            done_cnt_q <= 8'd0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                res_q    <= op_or;
                res_id_q <= win_idx;
                last     <= win_idx;
            end
            if (handshake) begin
                done_cnt_q <= done_cnt_q + 8'd1;
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.res       = res_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = (state == HOLD);
    assign bus.busy      = (state == HOLD);
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_or16_rr_sched.sv
// tb/tb_or16_rr_sched.sv - self-checking bench for or16_rr_sched
module tb_or16_rr_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    or16_rr_sched_if #(.WIDTH(16)) bus();

    or16_rr_sched #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [47:0] a;
        logic [47:0] b;
        logic        ready;
        logic [2:0]  egnt;
        logic        evalid;
        logic [15:0] eres;
        logic [1:0]  eid;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: abstract state derived from the scheduling rules.
    logic        m_valid;
    logic [15:0] m_res;
    logic [1:0]  m_id;
    int          m_last;
    int          m_cnt;

    logic        cur_rst;
    logic [2:0]  cur_req;
    logic [47:0] cur_a;
    logic [47:0] cur_b;
    logic        cur_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        if (cur_rst || (m_valid && !cur_ready)) return -1;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (cur_req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_gnt();
        int w;
        w = model_winner();
        if (w < 0) return 3'b000;
        return 3'(1 << w);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_res   = 16'h0;
        m_id    = 2'd0;
        m_last  = 2;
        m_cnt   = 0;
    endtask

    task automatic apply(input logic r, input logic [2:0] q, input logic [47:0] a,
                         input logic [47:0] b, input logic rdy);
        cur_rst   = r;
        cur_req   = q;
        cur_a     = a;
        cur_b     = b;
        cur_ready = rdy;
        rst           = r;
        bus.req       = q;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.res_ready = rdy;
        @(negedge clk);
        chk("model_gnt", 64'(bus.gnt), 64'(model_gnt()));
        chk("model_valid", 64'(bus.res_valid), 64'(m_valid));
        chk("model_busy", 64'(bus.busy), 64'(m_valid));
        chk("model_cnt", 64'(bus.done_cnt), 64'(m_cnt));
        if (m_valid) begin
            chk("model_res", 64'(bus.res), 64'(m_res));
            chk("model_id", 64'(bus.res_id), 64'(m_id));
        end
    endtask

    task automatic advance();
        int w;
        bit hs;
        w  = model_winner();
        hs = m_valid && cur_ready;
        if (cur_rst) begin
            model_reset();
        end else begin
            if (hs) m_cnt = (m_cnt + 1) % 256;
            if (w >= 0) begin
                m_res   = cur_a[w*16 +: 16] | cur_b[w*16 +: 16];
                m_id    = 2'(w);
                m_last  = w;
                m_valid = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [47:0] a,
                                input logic [47:0] b, input logic rdy, input logic [2:0] g,
                                input logic v, input logic [15:0] rs, input logic [1:0] id,
                                input logic [7:0] c);
        vec_t t;
        t.rst = r; t.req = q; t.a = a; t.b = b; t.ready = rdy;
        t.egnt = g; t.evalid = v; t.eres = rs; t.eid = id; t.ecnt = c;
        return t;
    endfunction

    localparam logic [47:0] A1  = {16'h1234, 16'h5678, 16'hF000};
    localparam logic [47:0] B1  = {16'h0000, 16'h0000, 16'h000F};
    localparam logic [47:0] A4  = {16'hFFFF, 16'h0001, 16'hFFFF};
    localparam logic [47:0] B4  = {16'hFFFF, 16'h0002, 16'hFFFF};
    localparam logic [47:0] A7  = {16'h0400, 16'h0020, 16'h0001};
    localparam logic [47:0] B7  = {16'h8000, 16'h0800, 16'h0010};

    initial begin
        logic [47:0] ra;
        logic [47:0] rb;

        // Power-up reset outside the model comparisons (outputs are unknown before it).
        rst = 1'b1; bus.req = 3'b000; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
        cur_rst = 1'b1; cur_req = 3'b000; cur_a = '0; cur_b = '0; cur_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();

        // Directed table: single op, bitwise OR, streaming 0,1,2,... and backpressure.
        vecs.push_back(mk(1, 3'b111, A7, B7, 1, 3'b000, 0, 16'h0,    2'd0, 8'd0));
        vecs.push_back(mk(0, 3'b001, A1, B1, 1, 3'b001, 0, 16'h0,    2'd0, 8'd0));
        vecs.push_back(mk(0, 3'b000, A1, B1, 1, 3'b000, 1, 16'hF00F, 2'd0, 8'd0));
        vecs.push_back(mk(0, 3'b000, A1, B1, 0, 3'b000, 0, 16'h0,    2'd0, 8'd1));
        vecs.push_back(mk(0, 3'b010, A4, B4, 0, 3'b010, 0, 16'h0,    2'd0, 8'd1));
        vecs.push_back(mk(0, 3'b000, A4, B4, 0, 3'b000, 1, 16'h0003, 2'd1, 8'd1));
        vecs.push_back(mk(0, 3'b000, A4, B4, 1, 3'b000, 1, 16'h0003, 2'd1, 8'd1));
        vecs.push_back(mk(1, 3'b111, A7, B7, 1, 3'b000, 0, 16'h0,    2'd0, 8'd2));
        vecs.push_back(mk(0, 3'b111, A7, B7, 1, 3'b001, 0, 16'h0,    2'd0, 8'd0));
        vecs.push_back(mk(0, 3'b111, A7, B7, 1, 3'b010, 1, 16'h0011, 2'd0, 8'd0));
        vecs.push_back(mk(0, 3'b111, A7, B7, 1, 3'b100, 1, 16'h0820, 2'd1, 8'd1));
        vecs.push_back(mk(0, 3'b111, A7, B7, 1, 3'b001, 1, 16'h8400, 2'd2, 8'd2));
        vecs.push_back(mk(0, 3'b111, A7, B7, 1, 3'b010, 1, 16'h0011, 2'd0, 8'd3));
        vecs.push_back(mk(0, 3'b111, A7, B7, 1, 3'b100, 1, 16'h0820, 2'd1, 8'd4));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 3'b110, A7, B7, 0, 3'b000, 1, 16'h8400, 2'd2, 8'd5));
        vecs.push_back(mk(0, 3'b110, A7, B7, 1, 3'b010, 1, 16'h8400, 2'd2, 8'd5));
        vecs.push_back(mk(0, 3'b000, A7, B7, 1, 3'b000, 1, 16'h0820, 2'd1, 8'd6));
        vecs.push_back(mk(0, 3'b000, A7, B7, 0, 3'b000, 0, 16'h0,    2'd0, 8'd7));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].ready);
            chk($sformatf("tab%0d_gnt", i), 64'(bus.gnt), 64'(vecs[i].egnt));
            chk($sformatf("tab%0d_valid", i), 64'(bus.res_valid), 64'(vecs[i].evalid));
            chk($sformatf("tab%0d_busy", i), 64'(bus.busy), 64'(vecs[i].evalid));
            chk($sformatf("tab%0d_cnt", i), 64'(bus.done_cnt), 64'(vecs[i].ecnt));
            if (vecs[i].evalid) begin
                chk($sformatf("tab%0d_res", i), 64'(bus.res), 64'(vecs[i].eres));
                chk($sformatf("tab%0d_id", i), 64'(bus.res_id), 64'(vecs[i].eid));
            end
            advance();
        end

        // Reset while holding a stalled result.
        apply(0, 3'b010, A7, B7, 0); advance();
        apply(0, 3'b000, A7, B7, 0);
        chk("hold_valid", 64'(bus.res_valid), 64'd1);
        advance();
        apply(1, 3'b111, A7, B7, 0);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        advance();
        apply(0, 3'b111, A7, B7, 1);
        chk("post_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("post_rst_cnt", 64'(bus.done_cnt), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_gnt", 64'(bus.gnt), 64'b001);
        advance();

        // 256 handshakes from reset wrap done_cnt.
        apply(1, 3'b000, A1, B1, 1); advance();
        apply(0, 3'b001, A1, B1, 1); advance();
        for (int i = 0; i < 255; i++) begin
            apply(0, 3'b001, A1, B1, 1); advance();
        end
        apply(0, 3'b001, A1, B1, 1);
        chk("cnt_255", 64'(bus.done_cnt), 64'd255);
        advance();
        apply(0, 3'b000, A1, B1, 1);
        chk("cnt_wrap", 64'(bus.done_cnt), 64'd0);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            apply(($urandom_range(0, 59) == 0), 3'($urandom()), ra, rb,
                  ($urandom_range(0, 3) != 0));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
